hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It generates per-stage hold, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It detects load-use hazards, sequences multi-cycle EX operations with a down-counter, and freezes the pipe while data memory is not ready. It works alongside the operand forwarding logic, covering the hazards that forwarding cannot resolve.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/hazard_loaduse_detect.sv | 26 ++
 rtl/hazard_controller.sv | 183 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing control.
package pipe_ctrl_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use comparator: flags an ID instruction that needs the
// result of a load still sitting in EX, which forwarding cannot supply in time.
module hazard_loaduse_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             i_idValid,
  input  logic [REG_W-1:0] i_idRs1,
  input  logic [REG_W-1:0] i_idRs2,
  input  logic             i_idUsesRs2,
  input  logic [REG_W-1:0] i_exRd,
  input  logic             i_exRegWrite,
  input  logic             i_exMemRead,
  output logic             o_loadUse
);

  logic w_exIsLoad;
  logic w_rs1Match;
  logic w_rs2Match;

  // Register zero never carries a dependency.
  assign w_exIsLoad = i_exMemRead && i_exRegWrite && (i_exRd != REG_ZERO);
  assign w_rs1Match = (i_exRd == i_idRs1);
  assign w_rs2Match = i_idUsesRs2 && (i_exRd == i_idRs2);
  assign o_loadUse  = w_exIsLoad && i_idValid && (w_rs1Match || w_rs2Match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: per-stage hold/bubble/flush for load-use,
// multi-cycle EX operations and data-memory wait states.
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_Rs1,
  input  logic [REG_W-1:0] ID_Rs2,
  input  logic             ID_UsesRs2,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             EX_McStart,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             flush_ifid,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam bit         MC_EN   = (MC_LATENCY > 1);
  localparam logic [3:0] MC_LOAD = MC_EN ? 4'(MC_LATENCY - 2) : 4'd0;

  hz_state_t        r_state;
  hz_state_t        w_nextState;
  logic [3:0]       r_mcCnt;
  logic [3:0]       w_nextCnt;
  logic             r_mcMask;
  logic             w_nextMask;
  logic [CNT_W-1:0] r_stallCount;

  logic w_loadUse;
  logic w_memStall;
  logic w_mcStart;
  logic w_pcHold, w_ifidHold, w_idexHold, w_idexBubble;
  logic w_exmemHold, w_exmemBubble, w_memwbBubble, w_flushIfid, w_mcBusy;

  hazard_loaduse_detect u_loaduse (
    .i_idValid    (ID_valid),
    .i_idRs1      (ID_Rs1),
    .i_idRs2      (ID_Rs2),
    .i_idUsesRs2  (ID_UsesRs2),
    .i_exRd       (EX_Rd),
    .i_exRegWrite (EX_RegWrite),
    .i_exMemRead  (EX_MemRead),
    .o_loadUse    (w_loadUse)
  );

  assign w_memStall = MEM_Req && !MEM_Ready;
  assign w_mcStart  = MC_EN && EX_McStart && !r_mcMask;

  always_comb begin
    w_nextState   = r_state;
    w_nextCnt     = r_mcCnt;
    w_nextMask    = 1'b0;
    w_pcHold      = 1'b0;
    w_ifidHold    = 1'b0;
    w_idexHold    = 1'b0;
    w_idexBubble  = 1'b0;
    w_exmemHold   = 1'b0;
    w_exmemBubble = 1'b0;
    w_memwbBubble = 1'b0;
    w_flushIfid   = 1'b0;
    w_mcBusy      = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_memStall) begin
          w_pcHold      = 1'b1;
          w_ifidHold    = 1'b1;
          w_idexHold    = 1'b1;
          w_exmemHold   = 1'b1;
          w_memwbBubble = 1'b1;
          w_nextState   = MEM_WAIT;
        end else if (w_mcStart) begin
          w_pcHold      = 1'b1;
          w_ifidHold    = 1'b1;
          w_idexHold    = 1'b1;
          w_exmemBubble = 1'b1;
          w_mcBusy      = 1'b1;
          w_nextCnt     = MC_LOAD;
          // A two-cycle op stalls only in its start cycle.
          if (MC_LOAD == 4'd0) begin
            w_nextState = RUN;
            w_nextMask  = 1'b1;
          end else begin
            w_nextState = MC_BUSY;
          end
        end else if (EX_BranchTaken) begin
          w_flushIfid  = 1'b1;
          w_idexBubble = 1'b1;
        end else if (w_loadUse) begin
          w_pcHold     = 1'b1;
          w_ifidHold   = 1'b1;
          w_idexBubble = 1'b1;
        end
      end
      MC_BUSY: begin
        w_pcHold      = 1'b1;
        w_ifidHold    = 1'b1;
        w_idexHold    = 1'b1;
        w_exmemBubble = 1'b1;
        w_mcBusy      = 1'b1;
        if (r_mcCnt != 4'd0) begin
          w_nextCnt = r_mcCnt - 4'd1;
        end
        if (r_mcCnt <= 4'd1) begin
          w_nextState = RUN;
          w_nextMask  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!MEM_Req) begin
          w_nextState = RUN;
        end else if (MEM_Ready) begin
          // The frozen EX instruction leaves now, so a pending taken branch flushes here.
          w_nextState = RUN;
          if (EX_BranchTaken) begin
            w_flushIfid  = 1'b1;
            w_idexBubble = 1'b1;
          end
        end else begin
          w_pcHold      = 1'b1;
          w_ifidHold    = 1'b1;
          w_idexHold    = 1'b1;
          w_exmemHold   = 1'b1;
          w_memwbBubble = 1'b1;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_mcCnt  <= 4'd0;
      r_mcMask <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_mcCnt  <= w_nextCnt;
      r_mcMask <= w_nextMask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCount <= '0;
    end else if (pc_hold && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

  // Reset must silence the controls at once, even with hazard inputs still active.
  assign pc_hold      = rst_n & w_pcHold;
  assign ifid_hold    = rst_n & w_ifidHold;
  assign idex_hold    = rst_n & w_idexHold;
  assign idex_bubble  = rst_n & w_idexBubble;
  assign exmem_hold   = rst_n & w_exmemHold;
  assign exmem_bubble = rst_n & w_exmemBubble;
  assign memwb_bubble = rst_n & w_memwbBubble;
  assign flush_ifid   = rst_n & w_flushIfid;
  assign mc_busy      = rst_n & w_mcBusy;
  assign stall_count  = r_stallCount;

  mcBusyNoMem: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == MC_BUSY) |-> !MEM_Req);
  memWaitNeedsReq: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == MEM_WAIT) |-> MEM_Req);

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (small counter width so
// saturation is reachable).
module tb_hazard_controller;

  localparam int MC_LATENCY = 4;
  localparam int CNT_W      = 4;

  // Control vector order: pc, ifid, idexHold, idexBubble, exmemHold,
  // exmemBubble, memwbBubble, flushIfid, mcBusy.
  localparam logic [8:0] QUIET = 9'b000000000;
  localparam logic [8:0] LU    = 9'b110100000;
  localparam logic [8:0] MC    = 9'b111001001;
  localparam logic [8:0] MEM   = 9'b111010100;
  localparam logic [8:0] BR    = 9'b000100010;

  logic             clk;
  logic             rst_n;
  logic             ID_valid;
  logic [3:0]       ID_Rs1;
  logic [3:0]       ID_Rs2;
  logic             ID_UsesRs2;
  logic [3:0]       EX_Rd;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic             EX_McStart;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;
  logic             pc_hold, ifid_hold, idex_hold, idex_bubble;
  logic             exmem_hold, exmem_bubble, memwb_bubble, flush_ifid, mc_busy;
  logic [CNT_W-1:0] stall_count;

  hazard_controller #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_valid       (ID_valid),
    .ID_Rs1         (ID_Rs1),
    .ID_Rs2         (ID_Rs2),
    .ID_UsesRs2     (ID_UsesRs2),
    .EX_Rd          (EX_Rd),
    .EX_RegWrite    (EX_RegWrite),
    .EX_MemRead     (EX_MemRead),
    .EX_McStart     (EX_McStart),
    .EX_BranchTaken (EX_BranchTaken),
    .MEM_Req        (MEM_Req),
    .MEM_Ready      (MEM_Ready),
    .pc_hold        (pc_hold),
    .ifid_hold      (ifid_hold),
    .idex_hold      (idex_hold),
    .idex_bubble    (idex_bubble),
    .exmem_hold     (exmem_hold),
    .exmem_bubble   (exmem_bubble),
    .memwb_bubble   (memwb_bubble),
    .flush_ifid     (flush_ifid),
    .mc_busy        (mc_busy),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [8:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sbQ[$];
  logic [CNT_W-1:0] tbStall;
  int               assertCount;
  int               failCount;
  logic [8:0]       obsCtl;

  assign obsCtl = {pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_hold,
                   exmem_bubble, memwb_bubble, flush_ifid, mc_busy};

  // Expected stall count is the model count before this cycle's pc_hold lands.
  task automatic applyStimulus(input string tag, input logic [8:0] ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.cnt = tbStall;
    sbQ.push_back(e);
    if (ctl[8] && (tbStall != '1)) tbStall = tbStall + 1'b1;
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (sbQ.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard empty observed=%b", obsCtl);
    end else begin
      e = sbQ.pop_front();
      assertCount++;
      assert (obsCtl === e.ctl) else begin
        failCount++;
        $error("[TB] FAIL %s ctl observed=%b expected=%b", e.tag, obsCtl, e.ctl);
      end
      assertCount++;
      assert (stall_count === e.cnt) else begin
        failCount++;
        $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", e.tag, stall_count, e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [8:0] ctl);
    applyStimulus(tag, ctl);
    checkOutput();
  endtask

  task automatic setEx(input logic mr, input logic rw, input logic [3:0] rd,
                       input logic mc, input logic br);
    EX_MemRead     = mr;
    EX_RegWrite    = rw;
    EX_Rd          = rd;
    EX_McStart     = mc;
    EX_BranchTaken = br;
  endtask

  task automatic setId(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u2);
    ID_valid   = v;
    ID_Rs1     = rs1;
    ID_Rs2     = rs2;
    ID_UsesRs2 = u2;
  endtask

  task automatic setMem(input logic req, input logic rdy);
    MEM_Req   = req;
    MEM_Ready = rdy;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    tbStall     = '0;
    rst_n       = 1'b0;
    setEx(0, 0, 4'd0, 0, 0);
    setId(0, 4'd0, 4'd0, 0);
    setMem(0, 0);

    // Reset with random activity on every input.
    for (int i = 0; i < 3; i++) begin
      setEx(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      setId(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      setMem(1'($urandom), 1'($urandom));
      step("resetRandom", QUIET);
    end
    setEx(0, 0, 4'd0, 0, 0);
    setId(0, 4'd0, 4'd0, 0);
    setMem(0, 0);
    rst_n = 1'b1;
    step("postReset", QUIET);

    // Load-use on Rs2, then the bubble reaches EX.
    setEx(1, 1, 4'd5, 0, 0);
    setId(1, 4'd3, 4'd5, 1);
    step("loadUseRs2", LU);
    setEx(0, 0, 4'd0, 0, 0);
    step("loadUseOneCycle", QUIET);
    setEx(1, 1, 4'd0, 0, 0);
    setId(1, 4'd0, 4'd0, 1);
    step("loadUseRdZero", QUIET);
    setEx(1, 1, 4'd5, 0, 0);
    setId(1, 4'd3, 4'd5, 0);
    step("loadUseNoRs2", QUIET);
    setEx(1, 1, 4'd7, 0, 0);
    setId(1, 4'd7, 4'd2, 0);
    step("loadUseRs1", LU);
    setId(0, 4'd7, 4'd2, 0);
    step("loadUseIdInvalid", QUIET);
    setEx(0, 1, 4'd7, 0, 0);
    setId(1, 4'd7, 4'd2, 0);
    step("aluNoStall", QUIET);
    setEx(0, 0, 4'd0, 0, 0);
    setId(0, 4'd0, 4'd0, 0);

    // Multi-cycle op with EX_McStart held through completion.
    setEx(0, 0, 4'd0, 1, 0);
    step("mcStart", MC);
    step("mcBusy1", MC);
    step("mcBusy2", MC);
    step("mcNoRetrigger", QUIET);
    setEx(0, 0, 4'd0, 0, 0);
    step("mcIdle", QUIET);

    // Memory wait with a multi-cycle op frozen in EX.
    setEx(0, 0, 4'd0, 1, 0);
    setMem(1, 0);
    for (int i = 0; i < 5; i++) step("memWait", MEM);
    setMem(1, 1);
    step("memReady", QUIET);
    setMem(0, 0);
    step("mcAfterMem", MC);
    step("mcAfterMemBusy1", MC);
    step("mcAfterMemBusy2", MC);
    step("mcAfterMemDone", QUIET);
    setEx(0, 0, 4'd0, 0, 0);
    step("idle2", QUIET);

    // Taken branch overrides a load-use match.
    setEx(1, 1, 4'd5, 0, 1);
    setId(1, 4'd5, 4'd1, 0);
    step("branchOverLoadUse", BR);
    setEx(0, 0, 4'd0, 0, 0);
    setId(0, 4'd0, 4'd0, 0);
    step("idle3", QUIET);

    // Taken branch while memory is stalled: flush waits for ready.
    setEx(0, 0, 4'd0, 0, 1);
    setMem(1, 0);
    step("branchMemStall", MEM);
    step("branchMemWait", MEM);
    setMem(1, 1);
    step("branchMemReady", BR);
    setEx(0, 0, 4'd0, 0, 0);
    setMem(0, 0);
    step("idle4", QUIET);

    // Reset in the second MC_BUSY cycle.
    setEx(0, 0, 4'd0, 1, 0);
    step("rstMcStart", MC);
    step("rstMcBusy1", MC);
    rst_n   = 1'b0;
    tbStall = '0;
    step("rstMidStall", QUIET);
    setEx(0, 0, 4'd0, 0, 0);
    rst_n = 1'b1;
    step("rstRelease", QUIET);
    setEx(1, 1, 4'd9, 0, 0);
    setId(1, 4'd1, 4'd9, 1);
    step("rstRunLoadUse", LU);
    setEx(0, 0, 4'd0, 0, 0);
    setId(0, 4'd0, 4'd0, 0);
    step("idle5", QUIET);

    // Long memory wait drives the stall counter into saturation.
    setMem(1, 0);
    for (int i = 0; i < 17; i++) step("memSaturate", MEM);
    setMem(1, 1);
    step("memSatReady", QUIET);
    setMem(0, 0);
    step("satHold", QUIET);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
